// File: rtl/adat_pkg.sv
// Shared ADAT frame geometry and channel-buffer address field widths.
// Used by the decoder, the channel buffer and the I2S serializer.
package adat_pkg;

    localparam int unsigned ADAT_CHANNELS = 8;
    localparam int unsigned SLOT_BITS     = 32;
    localparam int unsigned FRAME_BITS    = 256;

    // Channel-buffer address is {frame, channel, bit}; the frame field width is set per instance.
    localparam int unsigned CHAN_W       = $clog2(ADAT_CHANNELS);
    localparam int unsigned BIT_W        = $clog2(SLOT_BITS);
    localparam int unsigned FRAME_ADDR_W = CHAN_W + BIT_W;

    localparam int unsigned I2S_LANES = ADAT_CHANNELS / 2;
    localparam int unsigned LANE_W    = $clog2(I2S_LANES);
    localparam int unsigned POS_W     = BIT_W + 1;

endpackage

// File: rtl/i2s_timing_gen.sv
// I2S bit-clock divider and 64-period frame position counter.
// bclk and lrclk are registered from next-state values so they line up with div_cnt/pos.
module i2s_timing_gen
    import adat_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 8,
    parameter int unsigned DIV_W    = $clog2(BCLK_DIV)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    output logic [DIV_W-1:0] div_cnt,
    output logic [POS_W-1:0] pos,
    output logic             bclk,
    output logic             lrclk
);

    logic [DIV_W-1:0] div_d;
    logic [POS_W-1:0] pos_d;
    logic             div_wrap;

    always_comb begin
        div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
        div_d    = div_wrap ? '0 : div_cnt + 1'b1;
        pos_d    = div_wrap ? pos + 1'b1 : pos;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_cnt <= '0;
            pos     <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            div_cnt <= div_d;
            pos     <= pos_d;
            bclk    <= (div_d >= DIV_W'(BCLK_DIV / 2));
            lrclk   <= pos_d[POS_W-1];
        end
    end

endmodule

// File: rtl/adat_i2s_serializer.sv
// Reads the newest complete ADAT frame from the channel buffer and streams it
// as four standard I2S lanes (one-bit delay, MSB first), muting when unlocked.
module adat_i2s_serializer
    import adat_pkg::*;
#(
    parameter int unsigned BCLK_DIV      = 8,
    parameter int unsigned CIRC_BUF_BITS = 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_ni,
    output logic [CIRC_BUF_BITS+FRAME_ADDR_W-1:0] ram_read_addr_o,
    input  logic                                  ram_read_data_i,
    input  logic [CIRC_BUF_BITS-1:0]              last_good_frame_idx_i,
    input  logic                                  has_sync_i,
    output logic                                  i2s_bclk_o,
    output logic                                  i2s_lrclk_o,
    output logic [I2S_LANES-1:0]                  i2s_data_o,
    output logic                                  frame_start_o,
    output logic                                  frame_repeat_o
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);

    if ((BCLK_DIV % 2) != 0 || BCLK_DIV < 8) begin : g_bad_div
        $error("BCLK_DIV must be even and at least 8");
    end
    if (FRAME_BITS != ADAT_CHANNELS * SLOT_BITS || CHAN_W != LANE_W + 1) begin : g_bad_geom
        $error("inconsistent ADAT frame geometry");
    end

    logic [DIV_W-1:0]         div_cnt;
    logic [DIV_W-1:0]         div_m1;
    logic [POS_W-1:0]         pos;
    logic                     latch;
    logic                     fetch_en;
    logic                     cap_en;
    logic [LANE_W-1:0]        rd_lane;
    logic [LANE_W-1:0]        cap_lane;
    logic [CIRC_BUF_BITS-1:0] addr_frame;
    logic [CIRC_BUF_BITS-1:0] frame_q;
    logic                     mute_q;
    logic                     first_q;
    logic                     start_q;
    logic                     repeat_q;
    logic [I2S_LANES-1:0]     shadow_q;
    logic [I2S_LANES-1:0]     shadow_d;
    logic [I2S_LANES-1:0]     data_q;

    i2s_timing_gen #(
        .BCLK_DIV (BCLK_DIV),
        .DIV_W    (DIV_W)
    ) u_timing (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .div_cnt  (div_cnt),
        .pos      (pos),
        .bclk     (i2s_bclk_o),
        .lrclk    (i2s_lrclk_o)
    );

    always_comb begin
        latch    = (div_cnt == '0) && (pos == '0);
        fetch_en = (div_cnt < DIV_W'(I2S_LANES));
        // Past the fetch window the lane-3 address is repeated, i.e. the last one held.
        rd_lane  = fetch_en ? div_cnt[LANE_W-1:0] : LANE_W'(I2S_LANES - 1);
        div_m1   = div_cnt - 1'b1;
        cap_lane = div_m1[LANE_W-1:0];
        cap_en   = (div_cnt != '0) && (div_cnt <= DIV_W'(I2S_LANES));
        shadow_d = shadow_q;
        if (cap_en) begin
            shadow_d[cap_lane] = ram_read_data_i & ~mute_q;
        end
    end

    // The lane-0 read of bit 0 happens in the latch cycle itself, so it must already use
    // the incoming index; reset gating keeps the address at zero while held in reset.
    always_comb begin
        addr_frame = (latch && reset_ni) ? last_good_frame_idx_i : frame_q;
    end

    assign ram_read_addr_o = {addr_frame, rd_lane, pos[POS_W-1], pos[BIT_W-1:0]};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            frame_q  <= '0;
            mute_q   <= 1'b1;
            first_q  <= 1'b1;
            start_q  <= 1'b0;
            repeat_q <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            start_q  <= latch;
            repeat_q <= latch && !first_q && (last_good_frame_idx_i == frame_q);
            if (latch) begin
                frame_q <= last_good_frame_idx_i;
                mute_q  <= ~has_sync_i;
                first_q <= 1'b0;
            end
            shadow_q <= shadow_d;
            if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
                data_q <= shadow_q;
            end
        end
    end

    assign i2s_data_o     = data_q;
    assign frame_start_o  = start_q;
    assign frame_repeat_o = repeat_q;

endmodule

// File: tb/tb_adat_i2s_serializer.sv
// Scoreboard bench for adat_i2s_serializer: the stimulus pushes the expected lane bits and
// repeat flags per frame, a negedge monitor pops them on each bclk rise / frame_start pulse.
module tb_adat_i2s_serializer;

    localparam int unsigned BCLK_DIV = 8;
    localparam int unsigned CBB      = 3;
    localparam int unsigned AW       = CBB + 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] addr;
    logic          rdata = 1'b0;
    logic [CBB-1:0] last_good = '0;
    logic          has_sync = 1'b0;
    logic          bclk, lrclk, fs, rep;
    logic [3:0]    data;

    adat_i2s_serializer #(
        .BCLK_DIV      (BCLK_DIV),
        .CIRC_BUF_BITS (CBB)
    ) dut (
        .clk_i                 (clk),
        .reset_ni              (reset_n),
        .ram_read_addr_o       (addr),
        .ram_read_data_i       (rdata),
        .last_good_frame_idx_i (last_good),
        .has_sync_i            (has_sync),
        .i2s_bclk_o            (bclk),
        .i2s_lrclk_o           (lrclk),
        .i2s_data_o            (data),
        .frame_start_o         (fs),
        .frame_repeat_o        (rep)
    );

    always #5 clk = ~clk;

    // Channel buffer model: one-cycle read latency.
    logic mem [0:(1<<AW)-1];
    always @(posedge clk) rdata <= mem[addr];

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_data[$];
    logic       exp_rep[$];

    function automatic logic [31:0] word_of(input int f, input int n);
        if (f == 3) return 32'hA5A5_A5A5 ^ 32'(n);
        return 32'h9E37_79B9 * 32'(f * 8 + n + 1);
    endfunction

    // Stream bit k (0..63) of lane L: slot bit k%32 (offset 0 = MSB) of channel 2L + k/32.
    function automatic logic stream_bit(input int f, input int lane, input int k);
        logic [31:0] w;
        w = word_of(f, 2 * lane + k / 32);
        return w[31 - (k % 32)];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // ---------------- stimulus ----------------
    int   prev_f;
    logic prev_sync;
    bit   prev_valid = 1'b0;

    task automatic push_frame(input int f, input logic s, input logic r);
        logic [3:0] w;
        for (int p = 0; p < 64; p++) begin
            w = '0;
            for (int l = 0; l < 4; l++) begin
                if (p == 0) begin
                    if (prev_valid && prev_sync) w[l] = stream_bit(prev_f, l, 63);
                end else if (s) begin
                    w[l] = stream_bit(f, l, p - 1);
                end
            end
            exp_data.push_back(w);
        end
        exp_rep.push_back(r);
        prev_f     = f;
        prev_sync  = s;
        prev_valid = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_frame(input int f, input logic s, input logic r);
        last_good = CBB'(f);
        has_sync  = s;
        push_frame(f, s, r);
    endtask

    task automatic run_frame(input int f, input logic s, input logic r);
        start_frame(f, s, r);
        step(512);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"}, 32'(bclk), 32'd0);
        check({tag, "_lrclk"}, 32'(lrclk), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_frame_start"}, 32'(fs), 32'd0);
        check({tag, "_frame_repeat"}, 32'(rep), 32'd0);
    endtask

    initial begin
        for (int f = 0; f < 8; f++)
            for (int ch = 0; ch < 8; ch++)
                for (int b = 0; b < 32; b++) begin
                    logic [31:0] w;
                    w = word_of(f, ch);
                    mem[AW'(f * 256 + ch * 32 + b)] = w[31 - b];
                end

        last_good = 3'd6;
        has_sync  = 1'b1;
        step(3);
        check_reset_outputs("por");

        reset_n = 1'b1;
        run_frame(3, 1'b1, 1'b0);    // reference pattern, first latch: no repeat
        run_frame(3, 1'b0, 1'b1);    // unlocked: whole frame muted
        run_frame(3, 1'b1, 1'b1);    // lock back: data resumes
        run_frame(5, 1'b1, 1'b0);
        run_frame(5, 1'b1, 1'b1);    // held index: one repeat pulse
        run_frame(7, 1'b1, 1'b0);
        run_frame(0, 1'b1, 1'b0);    // 7 -> 0 wrap is a new index

        // Inputs change at pos 20; the frame in progress must keep index 6 and stay unmuted.
        start_frame(6, 1'b1, 1'b0);
        step(162);
        last_good = 3'd2;
        has_sync  = 1'b0;
        step(350);
        run_frame(2, 1'b1, 1'b0);

        // Reset pulse at pos 40, div 5 (bclk and lrclk both high).
        start_frame(4, 1'b1, 1'b0);
        step(325);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_data.delete();
        exp_rep.delete();
        prev_valid = 1'b0;
        step(3);
        reset_n = 1'b1;
        // frame_q is 0 after reset, so index 0 would look like a repeat without the first-latch rule.
        run_frame(0, 1'b1, 1'b0);
        run_frame(0, 1'b1, 1'b1);

        check("data_queue_drained", 32'(exp_data.size()), 32'd0);
        check("repeat_queue_drained", 32'(exp_rep.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- monitor ----------------
    int       cyc = 0;
    int       since_rel = 0;
    int       last_fs = 0;
    int       last_rise = 0;
    bit       have_fs = 1'b0;
    bit       have_rise = 1'b0;
    logic     prev_bclk = 1'b0;
    logic [5:0] rise_idx = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                since_rel = 0;
                have_fs   = 1'b0;
                have_rise = 1'b0;
                prev_bclk = 1'b0;
            end else begin
                since_rel++;
                if (fs) begin
                    // First latch is on the first clock edge after release: second negedge sample.
                    if (have_fs) check("frame_start_spacing", 32'(cyc - last_fs), 32'd512);
                    else         check("frame_start_after_release", 32'(since_rel), 32'd2);
                    have_fs  = 1'b1;
                    last_fs  = cyc;
                    rise_idx = '0;
                    if (exp_rep.size() == 0) begin
                        n_checks++;
                        $display("FAIL repeat_queue: got frame_start, expected no pending frame");
                    end else begin
                        check("frame_repeat", 32'(rep), 32'(exp_rep.pop_front()));
                    end
                end else if (rep) begin
                    check("repeat_without_start", 32'(rep), 32'd0);
                end
                if (bclk && !prev_bclk) begin
                    if (have_rise) check("bclk_period", 32'(cyc - last_rise), 32'(BCLK_DIV));
                    have_rise = 1'b1;
                    last_rise = cyc;
                    check("lrclk", 32'(lrclk), 32'(rise_idx[5]));
                    rise_idx = rise_idx + 6'd1;
                    if (exp_data.size() == 0) begin
                        n_checks++;
                        $display("FAIL data_queue: got bclk rise, expected no pending bit");
                    end else begin
                        check("lane_data", 32'(data), 32'(exp_data.pop_front()));
                    end
                end
                prev_bclk = bclk;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected bench completion");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/adat_i2s_serializer.md
ADAT_I2S_SERIALIZER -- requirements
Module: adat_i2s_serializer

Interface
REQ-001 Parameter BCLK_DIV, default 8, meaning clk_i cycles per I2S bit-clock period; SHALL be even and >= 8.
REQ-002 Parameter CIRC_BUF_BITS, default 3, meaning frame-index width of the channel buffer (2^CIRC_BUF_BITS frames of 256 bits).
REQ-003 clk_i  in  1  single clock, same clock as the channel buffer; reset is asynchronous and active-low.
REQ-004 reset_ni  in  1  asynchronous active-low reset.
REQ-005 ram_read_addr_o  out  CIRC_BUF_BITS+8  channel-buffer read address {frame, channel[2:0], bit[4:0]}.
REQ-006 ram_read_data_i  in  1  channel-buffer read data, valid one clk_i cycle after the address.
REQ-007 last_good_frame_idx_i  in  CIRC_BUF_BITS  index of the newest complete frame written by the decoder.
REQ-008 has_sync_i  in  1  decoder lock indication.
REQ-009 i2s_bclk_o  out  1  I2S bit clock, 64 periods per frame.
REQ-010 i2s_lrclk_o  out  1  word select, 0 = left (even channel), 1 = right (odd channel).
REQ-011 i2s_data_o  out  4  serial data lanes; lane L carries channels 2L (left) and 2L+1 (right).
REQ-012 frame_start_o  out  1  one-cycle pulse when a frame index is latched.
REQ-013 frame_repeat_o  out  1  one-cycle pulse when the latched index equals the previously latched index.

Function
REQ-014 Divider div_cnt counts 0..BCLK_DIV-1 and wraps; i2s_bclk_o SHALL be 0 for div_cnt < BCLK_DIV/2, 1 otherwise (registered).
REQ-015 Position counter pos (6 bits) SHALL increment on each div_cnt wrap, wrapping 63 -> 0; i2s_lrclk_o = pos[5].
REQ-016 At div_cnt==0 and pos==0 the block SHALL latch frame_q <= last_good_frame_idx_i and mute_q <= ~has_sync_i, and pulse frame_start_o.
REQ-017 frame_repeat_o SHALL pulse in the same cycle as frame_start_o when the new index equals frame_q's previous value, except on the first latch after reset.
REQ-018 During period pos, at div_cnt 0..3, ram_read_addr_o SHALL present {frame_q, 2*lane+pos[5], pos[4:0]} for lane = div_cnt; address offset 0 in a slot is the MSB.
REQ-019 Returned bits SHALL be captured into a 4-bit shadow register at div_cnt 1..4 (lane = div_cnt-1), forced to 0 when mute_q is 1.
REQ-020 At div_cnt==0 (bclk falling) i2s_data_o SHALL load the shadow register, giving standard I2S one-bit delay: stream bit k appears during period k+1 (mod 64), MSB first.
REQ-021 During div_cnt >= 4 ram_read_addr_o SHALL hold its last value.
REQ-022 Changes of last_good_frame_idx_i or has_sync_i outside the latch cycle SHALL have no effect on the frame in progress.
REQ-023 Frame index wrap (max -> 0) SHALL be treated as an ordinary new index (no repeat pulse).

Reset
REQ-024 While reset_ni is 0: div_cnt, pos, frame_q, shadow, i2s_bclk_o, i2s_lrclk_o, i2s_data_o, ram_read_addr_o, frame_start_o, frame_repeat_o SHALL be 0; mute_q SHALL be 1; first-latch flag set.
REQ-025 On reset release the first frame latch SHALL occur in the first clk_i cycle after release (div_cnt==0, pos==0).
REQ-026 Reset asserted mid-frame SHALL abort output immediately; no partial frame resumes.

Structure
REQ-027 Package adat_pkg SHALL hold ADAT_CHANNELS=8, SLOT_BITS=32, FRAME_BITS=256, and the address-field widths shared with the decoder and channel buffer.
REQ-028 One sub-module i2s_timing_gen SHALL own div_cnt, pos, i2s_bclk_o and i2s_lrclk_o and export div_cnt/pos to the fetch logic.

Verification
REQ-029 RAM preloaded with frame 3 = channel n word 0xA5A5A5A5 ^ n, last_good=3, has_sync=1 -> each lane reproduces its channel pair bit-exact, MSB at pos 1 (left) and pos 33 (right).
REQ-030 has_sync_i=0 at latch with non-zero RAM -> all four lanes 0 for the whole frame; has_sync_i=1 next latch -> data resumes.
REQ-031 last_good_frame_idx_i held at 5 for two frames -> frame_repeat_o pulses once on the second frame_start_o; 7 -> 0 transition -> no pulse.
REQ-032 last_good_frame_idx_i changed at pos=20 -> no address with the new index until next pos==0 latch.
REQ-033 BCLK_DIV=8 -> bclk period 8 cycles, lrclk period 512 cycles, frame_start_o every 512 cycles.
REQ-034 reset_ni pulsed low at pos=40 -> all outputs 0 asynchronously, mute_q=1, first latch one cycle after release without frame_repeat_o.
